kv_store: RTL

Key-vault storage responder: the slave end of the key-vault read/write interface used by the crypto wrappers' KV clients. It holds ENTRIES keys of DWORDS 32-bit words each, serves dword reads and writes from a client, and enforces per-entry write and use locks. It also runs a sequential zeroization sweep on request. Software configures it through a 32-bit cs/we register port.

---
 rtl/kv_store_if.sv | 44 ++++
 rtl/kv_store.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/kv_store_if.sv
// Key-vault bundle: software register port plus the client read/write
// channels. The client (crypto wrapper / software) is the master; the
// key store is the slave.
interface kv_store_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int ENTRY_W    = 3,
    parameter int OFFSET_W   = 4
);
    logic                  cs;
    logic                  we;
    logic [ADDR_WIDTH-1:0] address;
    logic [31:0]           write_data;
    logic [31:0]           read_data;

    logic                  kv_rd_en;
    logic [ENTRY_W-1:0]    kv_rd_entry;
    logic [OFFSET_W-1:0]   kv_rd_offset;
    logic                  kv_rd_valid;
    logic [31:0]           kv_rd_data;
    logic                  kv_rd_err;

    logic                  kv_wr_en;
    logic [ENTRY_W-1:0]    kv_wr_entry;
    logic [OFFSET_W-1:0]   kv_wr_offset;
    logic [31:0]           kv_wr_data;
    logic                  kv_wr_last;
    logic                  kv_wr_err;

    logic                  busy;

    modport master (
        output cs, we, address, write_data,
        output kv_rd_en, kv_rd_entry, kv_rd_offset,
        output kv_wr_en, kv_wr_entry, kv_wr_offset, kv_wr_data, kv_wr_last,
        input  read_data, kv_rd_valid, kv_rd_data, kv_rd_err, kv_wr_err, busy
    );

    modport slave (
        input  cs, we, address, write_data,
        input  kv_rd_en, kv_rd_entry, kv_rd_offset,
        input  kv_wr_en, kv_wr_entry, kv_wr_offset, kv_wr_data, kv_wr_last,
        output read_data, kv_rd_valid, kv_rd_data, kv_rd_err, kv_wr_err, busy
    );
endinterface

// File: rtl/kv_store.sv
// Key-vault storage responder: ENTRIES keys of DWORDS words, per-entry
// write/use locks, 1-cycle client reads, and a sequential zeroization sweep.
module kv_store #(
    parameter int ENTRIES    = 8,
    parameter int DWORDS     = 12,
    parameter int ADDR_WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    kv_store_if.slave  bus
);
    localparam int EW = $clog2(ENTRIES);
    localparam int OW = $clog2(DWORDS);

    typedef enum logic {IDLE, CLEAR} state_t;

    logic [31:0]        mem [ENTRIES][DWORDS];
    logic [ENTRIES-1:0] lock_wr, lock_use, valid, valid_nxt;
    logic [ENTRIES-1:0] mask_q, new_mask;
    logic [EW-1:0]      cnt_entry;
    logic [OW-1:0]      cnt_dword;
    state_t             state;

    logic               rd_vld_p1, rd_err_p1, wr_err_p1;
    logic [31:0]        rd_data_p1;
    logic [31:0]        read_data_c;

    logic               busy, sw_wr, ctrl_hit, clr_hit, stat_hit, clr_start;
    logic               wr_ok, rd_ok;
    logic [EW-1:0]      ctrl_idx;
    logic               unused_wdata;

    function automatic logic in_range(input int idx, input int lim);
        return idx < lim;
    endfunction

    assign busy      = (state == CLEAR);
    assign sw_wr     = bus.cs && bus.we;
    assign ctrl_hit  = (bus.address < ADDR_WIDTH'(ENTRIES * 4)) && (bus.address[1:0] == 2'b00);
    assign clr_hit   = (bus.address == ADDR_WIDTH'('h40));
    assign stat_hit  = (bus.address == ADDR_WIDTH'('h44));
    assign ctrl_idx  = bus.address[EW+1:2];
    assign new_mask  = bus.write_data[ENTRIES-1:0] & ~lock_wr;
    assign clr_start = sw_wr && clr_hit && (state == IDLE) && (bus.write_data[ENTRIES-1:0] != '0);
    assign unused_wdata = ^bus.write_data[31:ENTRIES];

    assign wr_ok = bus.kv_wr_en
                && in_range(int'(bus.kv_wr_entry), ENTRIES)
                && in_range(int'(bus.kv_wr_offset), DWORDS)
                && !lock_wr[bus.kv_wr_entry] && !busy;

    assign rd_ok = in_range(int'(bus.kv_rd_entry), ENTRIES)
                && in_range(int'(bus.kv_rd_offset), DWORDS)
                && valid[bus.kv_rd_entry] && !lock_use[bus.kv_rd_entry] && !busy;

    // Next valid vector: client write effects first, sweep start overrides them.
    always_comb begin
        valid_nxt = valid;
        if (wr_ok) begin
            if (bus.kv_wr_offset == '0) valid_nxt[bus.kv_wr_entry] = 1'b0;
            if (bus.kv_wr_last)         valid_nxt[bus.kv_wr_entry] = 1'b1;
        end
        if (clr_start) valid_nxt = valid_nxt & ~new_mask;
    end

    // Software register read mux; zero whenever not reading.
    always_comb begin
        read_data_c = '0;
        if (bus.cs && !bus.we) begin
            if (ctrl_hit)
                read_data_c = {29'd0, valid[ctrl_idx], lock_use[ctrl_idx], lock_wr[ctrl_idx]};
            else if (stat_hit)
                read_data_c = {31'd0, busy};
        end
    end

    // Sticky locks: software can only set them; reset is the only way out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_wr  <= '0;
            lock_use <= '0;
        end else if (sw_wr && ctrl_hit) begin
            lock_wr[ctrl_idx]  <= lock_wr[ctrl_idx]  | bus.write_data[0];
            lock_use[ctrl_idx] <= lock_use[ctrl_idx] | bus.write_data[1];
        end
    end

    // Storage, valid bits and the clear sweep FSM share one owner of mem.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++)
                for (int j = 0; j < DWORDS; j++)
                    mem[i][j] <= '0;
            valid     <= '0;
            mask_q    <= '0;
            cnt_entry <= '0;
            cnt_dword <= '0;
            state     <= IDLE;
        end else begin
            valid <= valid_nxt;
            if (wr_ok) mem[bus.kv_wr_entry][bus.kv_wr_offset] <= bus.kv_wr_data;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        mask_q    <= new_mask;
                        cnt_entry <= '0;
                        cnt_dword <= '0;
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (mask_q[cnt_entry]) mem[cnt_entry][cnt_dword] <= '0;
                    if (cnt_dword == OW'(DWORDS - 1)) begin
                        cnt_dword <= '0;
                        if (cnt_entry == EW'(ENTRIES - 1)) state <= IDLE;
                        else cnt_entry <= cnt_entry + 1'b1;
                    end else begin
                        cnt_dword <= cnt_dword + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---- stage p1: registered client read response and write-drop pulse ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_p1  <= 1'b0;
            rd_err_p1  <= 1'b0;
            rd_data_p1 <= '0;
            wr_err_p1  <= 1'b0;
        end else begin
            rd_vld_p1 <= bus.kv_rd_en;
            wr_err_p1 <= bus.kv_wr_en && !wr_ok;
            if (bus.kv_rd_en) begin
                rd_err_p1  <= !rd_ok;
                rd_data_p1 <= rd_ok ? mem[bus.kv_rd_entry][bus.kv_rd_offset] : 32'd0;
            end
        end
    end

    assign bus.read_data   = read_data_c;
    assign bus.kv_rd_valid = rd_vld_p1;
    assign bus.kv_rd_data  = rd_data_p1;
    assign bus.kv_rd_err   = rd_err_p1;
    assign bus.kv_wr_err   = wr_err_p1;
    assign bus.busy        = busy;
endmodule
